riscv_store_monitor: RTL and testbench
======================================

# riscv_store_monitor

Synthesizable self-check block on the data-memory store port of the pipelined RV32IM `top`. It watches every store, declares PASS on the expected signature store, FAIL on any unexpected store, and TIMEOUT if neither occurs within a cycle budget. Results are published as sticky status, cycle and store counters, and an LED status byte. It lets the same pass/fail decision run on the FPGA board as well as in simulation.

## Interface
- `PASS_ADDR`, 32'd100: store address that signals test completion.
- `PASS_DATA`, 32'd25: data value required at `PASS_ADDR` for PASS.
- `SCRATCH_ADDR`, 32'd96: store address that is always tolerated.
- `TIMEOUT_CYCLES`, 1000: RUN-cycle budget before TIMEOUT; legal range 1 to 2^32-1.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `MemWrite` in 1: store strobe from `top`.
- `DataAdr` in 32: store byte address from `top`.
- `WriteData` in 32: store data from `top`.
- `status` out 2: 0 RUN, 1 PASS, 2 FAIL, 3 TIMEOUT.
- `done` out 1: high in any terminal state.
- `cycles` out 32: number of RUN cycles elapsed.
- `store_count` out 16: number of stores sampled, saturating.
- `fail_addr` out 32: `DataAdr` of the store that caused FAIL; 0 otherwise.
- `fail_data` out 32: `WriteData` of the store that caused FAIL; 0 otherwise.
- `led` out 8: `{status, store_count[5:0]}`.

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN. PASS, FAIL and TIMEOUT are sticky until `reset`.
- In RUN, on each rising edge with `MemWrite`=1:
  - If `DataAdr`==`PASS_ADDR` and `WriteData`==`PASS_DATA`, go to PASS.
  - Else if `DataAdr`==`SCRATCH_ADDR`, stay in RUN. Any data value is accepted.
  - Else go to FAIL and capture `fail_addr`/`fail_data`. This includes `PASS_ADDR` stored with wrong data.
- In RUN, with no decisive store, go to TIMEOUT at the edge where `cycles`==`TIMEOUT_CYCLES`-1.
- Same edge, decisive store vs timeout: the store wins, giving PASS or FAIL.
- `cycles` increments by 1 on each RUN edge and freezes on entry to a terminal state. Value on entry to TIMEOUT: `TIMEOUT_CYCLES`.
- `store_count` counts every `MemWrite` edge in RUN, including the decisive one. It stops at 16'hFFFF and does not count in terminal states.
- Stores arriving in a terminal state are ignored. No output changes.
- All comparisons are full 32-bit equality. No byte masking.

## Timing
- All outputs are registered. Reset values: `status`=0, `done`=0, `cycles`=0, `store_count`=0, `fail_addr`=0, `fail_data`=0, `led`=0.
- Inputs are sampled on the rising edge. A decisive store at edge N makes `status`/`done` valid after edge N (latency 1).
- `reset` asserted at any edge, including mid-RUN or in a terminal state, restores all reset values at that edge. The first RUN cycle counted is the first edge with `reset`=0.
- `done` and `status` never revert without `reset`.
- `led` tracks `status` and `store_count` with no extra latency.

## Structure
- Package `riscv_mon_pkg` holds:
  - `mon_state_t` enum (RUN=2'd0, PASS=2'd1, FAIL=2'd2, TIMEOUT=2'd3), cast directly to `status`.
  - LED field position constants.
- Single module. No sub-module is needed; counters and FSM are inline.
- Instantiated beside `top`, driven from its `MemWrite`/`DataAdr`/`WriteData` outputs.

## Test plan
- Reset release, then stores (96, 7), (96, 9), (100, 25) on edges 3, 5, 8 → PASS after edge 8; `store_count`=3, `cycles`=8, `led`=8'h43.
- Store (100, 24) → FAIL; `fail_addr`=100, `fail_data`=24, `led[7:6]`=2.
- Store (200, 25) → FAIL; `fail_addr`=200. A following (100, 25) leaves `status`=2 and `store_count`=1.
- `TIMEOUT_CYCLES`=16, no stores → TIMEOUT after edge 16; `cycles`=16. Variant with (100, 25) on edge 16 → PASS.
- `reset` pulsed for one cycle mid-RUN after 5 stores → all outputs 0 next cycle. A later (100, 25) → PASS with `store_count`=1.
- 70000 stores to 96 with `TIMEOUT_CYCLES`=100000 → `store_count` saturates at 16'hFFFF, `status` remains RUN.

Source files
------------

// File: rtl/riscv_mon_pkg.sv
// Shared types and constants for the RV32IM store-port self-check monitor.
package riscv_mon_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_t;

  // The LED byte is {status, store_count[5:0]}.
  localparam int LED_STATUS_LSB = 6;
  localparam int LED_STATUS_W   = 2;
  localparam int LED_COUNT_LSB  = 0;
  localparam int LED_COUNT_W    = 6;

endpackage

// File: rtl/riscv_store_monitor.sv
// Watches the data-memory store port and reaches a sticky PASS/FAIL/TIMEOUT verdict.
// The verdict, counters and LED byte are all driven straight from registers.
module riscv_store_monitor
  import riscv_mon_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [1:0]  status,
  output logic        done,
  output logic [31:0] cycles,
  output logic [15:0] store_count,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [7:0]  led
);

  mon_state_t  state_q, state_d;
  logic [31:0] cycles_q;
  logic [15:0] store_count_q;
  logic [31:0] fail_addr_q, fail_data_q;

  logic pass_hit, scratch_hit, timeout_hit;
  logic count_inc, fail_capture;

  assign pass_hit    = (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
  assign scratch_hit = (DataAdr == SCRATCH_ADDR);
  // Timeout fires on the edge that moves cycles up to TIMEOUT_CYCLES.
  assign timeout_hit = (cycles_q == (TIMEOUT_CYCLES - 32'd1));

  always_comb begin
    state_d      = state_q;
    count_inc    = 1'b0;
    fail_capture = 1'b0;
    case (state_q)
      RUN: begin
        count_inc = MemWrite;
        // A decisive store on the same edge as the timeout takes priority.
        if (MemWrite && pass_hit) begin
          state_d = PASS;
        end else if (MemWrite && !scratch_hit) begin
          state_d      = FAIL;
          fail_capture = 1'b1;
        end else if (timeout_hit) begin
          state_d = TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      cycles_q      <= 32'd0;
      store_count_q <= 16'd0;
      fail_addr_q   <= 32'd0;
      fail_data_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) begin
        cycles_q <= cycles_q + 32'd1;
      end
      if (count_inc && (store_count_q != 16'hFFFF)) begin
        store_count_q <= store_count_q + 16'd1;
      end
      if (fail_capture) begin
        fail_addr_q <= DataAdr;
        fail_data_q <= WriteData;
      end
    end
  end

  assign status      = state_q;
  assign done        = (state_q != RUN);
  assign cycles      = cycles_q;
  assign store_count = store_count_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

  assign led[LED_STATUS_LSB +: LED_STATUS_W] = state_q;
  assign led[LED_COUNT_LSB  +: LED_COUNT_W]  = store_count_q[LED_COUNT_W-1:0];

endmodule

// File: tb/tb_riscv_store_monitor.sv
// Directed bench for riscv_store_monitor: two instances (short and long timeout)
// share stimulus and are checked every cycle against a behavioural model.
module tb_riscv_store_monitor;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 32'd0;
  logic [31:0] WriteData = 32'd0;

  always #5 clk = ~clk;

  logic [1:0]  s_status, l_status;
  logic        s_done, l_done;
  logic [31:0] s_cycles, l_cycles;
  logic [15:0] s_count, l_count;
  logic [31:0] s_faddr, l_faddr, s_fdata, l_fdata;
  logic [7:0]  s_led, l_led;

  riscv_store_monitor #(.TIMEOUT_CYCLES(32'd16)) dut_s (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .status(s_status), .done(s_done), .cycles(s_cycles),
    .store_count(s_count), .fail_addr(s_faddr), .fail_data(s_fdata), .led(s_led)
  );

  riscv_store_monitor #(.TIMEOUT_CYCLES(32'd100000)) dut_l (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .status(l_status), .done(l_done), .cycles(l_cycles),
    .store_count(l_count), .fail_addr(l_faddr), .fail_data(l_fdata), .led(l_led)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int     st;    // 0 run, 1 pass, 2 fail, 3 timeout
    longint cyc;
    int     cnt;
    logic [31:0] fa;
    logic [31:0] fd;
  } mdl_t;

  mdl_t m_s, m_l;

  function automatic mdl_t step(input mdl_t m, input longint limit, input logic mw,
                                input logic [31:0] a, input logic [31:0] d);
    mdl_t r = m;
    if (r.st != 0) return r;
    r.cyc = r.cyc + 1;
    if (mw) begin
      if (r.cnt < 65535) r.cnt = r.cnt + 1;
      if (a == 32'd100 && d == 32'd25) begin
        r.st = 1;
      end else if (a != 32'd96) begin
        r.st = 2;
        r.fa = a;
        r.fd = d;
      end
    end
    if (r.st == 0 && r.cyc == limit) r.st = 3;
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_s <= '0;
      m_l <= '0;
    end else begin
      m_s <= step(m_s, 16, MemWrite, DataAdr, WriteData);
      m_l <= step(m_l, 100000, MemWrite, DataAdr, WriteData);
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic check_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input string p, input mdl_t m, input logic [1:0] st, input logic dn,
                          input logic [31:0] cy, input logic [15:0] cn, input logic [31:0] fa,
                          input logic [31:0] fd, input logic [7:0] ld);
    logic [1:0] est;
    logic [5:0] ecnt;
    est  = 2'(m.st);
    ecnt = 6'(m.cnt);
    chk({p, ".status"}, 64'(st), 64'(est));
    chk({p, ".done"}, 64'(dn), 64'(m.st != 0));
    chk({p, ".cycles"}, 64'(cy), 64'(m.cyc));
    chk({p, ".store_count"}, 64'(cn), 64'(m.cnt));
    chk({p, ".fail_addr"}, 64'(fa), 64'(m.fa));
    chk({p, ".fail_data"}, 64'(fd), 64'(m.fd));
    chk({p, ".led"}, 64'(ld), 64'({est, ecnt}));
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      chk_inst("s", m_s, s_status, s_done, s_cycles, s_count, s_faddr, s_fdata, s_led);
      chk_inst("l", m_l, l_status, l_done, l_cycles, l_count, l_faddr, l_fdata, l_led);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = mw;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_on = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();
    chk("reset.status", 64'(l_status), 64'd0);
    chk("reset.led", 64'(l_led), 64'd0);
    chk("reset.cycles", 64'(l_cycles), 64'd0);

    // Stores on edges 3, 5, 8 -> PASS after edge 8.
    idle(2); cyc(1'b1, 32'd96, 32'd7);
    idle(1); cyc(1'b1, 32'd96, 32'd9);
    idle(2); cyc(1'b1, 32'd100, 32'd25);
    chk("pass.status", 64'(l_status), 64'd1);
    chk("pass.count", 64'(l_count), 64'd3);
    chk("pass.cycles", 64'(l_cycles), 64'd8);
    chk("pass.led", 64'(l_led), 64'h43);
    cyc(1'b1, 32'd300, 32'd1);
    idle(3);
    chk("pass.sticky", 64'(l_status), 64'd1);
    chk("pass.frozen_cycles", 64'(l_cycles), 64'd8);

    // Wrong data at the pass address.
    do_reset();
    cyc(1'b1, 32'd100, 32'd24);
    chk("fail1.status", 64'(l_status), 64'd2);
    chk("fail1.addr", 64'(l_faddr), 64'd100);
    chk("fail1.data", 64'(l_fdata), 64'd24);
    chk("fail1.led_status", 64'(l_led[7:6]), 64'd2);

    // Unexpected address, then a late pass store that must be ignored.
    do_reset();
    cyc(1'b1, 32'd200, 32'd25);
    cyc(1'b1, 32'd100, 32'd25);
    idle(1);
    chk("fail2.addr", 64'(l_faddr), 64'd200);
    chk("fail2.status", 64'(l_status), 64'd2);
    chk("fail2.count", 64'(l_count), 64'd1);

    // Short instance times out after edge 16.
    do_reset();
    idle(15);
    chk("to.before", 64'(s_status), 64'd0);
    chk("to.before_cycles", 64'(s_cycles), 64'd15);
    idle(1);
    chk("to.status", 64'(s_status), 64'd3);
    chk("to.cycles", 64'(s_cycles), 64'd16);
    idle(4);
    chk("to.frozen", 64'(s_cycles), 64'd16);

    // Decisive store on the timeout edge wins.
    do_reset();
    idle(15); cyc(1'b1, 32'd100, 32'd25);
    chk("to_pass.status", 64'(s_status), 64'd1);
    chk("to_pass.cycles", 64'(s_cycles), 64'd16);
    do_reset();
    idle(15); cyc(1'b1, 32'd300, 32'd5);
    chk("to_fail.status", 64'(s_status), 64'd2);
    chk("to_fail.addr", 64'(s_faddr), 64'd300);

    // Mid-run reset pulse.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'd96, 32'(i));
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mid.status", 64'(l_status), 64'd0);
    chk("mid.count", 64'(l_count), 64'd0);
    chk("mid.cycles", 64'(l_cycles), 64'd0);
    chk("mid.led", 64'(l_led), 64'd0);
    idle(3); cyc(1'b1, 32'd100, 32'd25);
    chk("mid.pass", 64'(l_status), 64'd1);
    chk("mid.pass_count", 64'(l_count), 64'd1);

    // Saturation of the store counter.
    do_reset();
    for (int i = 0; i < 70000; i++) cyc(1'b1, 32'd96, 32'(i));
    chk("sat.count", 64'(l_count), 64'hFFFF);
    chk("sat.status", 64'(l_status), 64'd0);
    chk("sat.led", 64'(l_led), 64'h3F);

    idle(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
